// File: rtl/mod_exp_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mod_exp_param_pkg
//  Purpose  : Shared definitions for the modular exponentiator: default
//             operand/exponent widths and the controller state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package mod_exp_param_pkg;

    localparam int c_default_width     = 512;
    localparam int c_default_exp_width = 512;

    // Controller states; the encoding is fixed so waveforms stay readable.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TO_MONT   = 3'd1,
        ST_SCAN      = 3'd2,
        ST_SQUARE    = 3'd3,
        ST_MULT      = 3'd4,
        ST_FROM_MONT = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mod_exp_param_montgomery_mult.sv
`default_nettype none
// ============================================================================
//  Module   : montgomery_mult
//  Purpose  : Bit-serial radix-2 Montgomery multiplier.
//             result = a * b * 2^-WIDTH mod m  (m odd, b < m).
//             One bit of a is consumed per clock; the final conditional
//             subtraction is performed here so the result is always < m.
//  Ports    : clk, resetn (async, active low)
//             start  - one-cycle request, ignored while a product is running
//             a,b,m  - operands and modulus, captured on start
//             done   - one-cycle pulse, result valid in the same cycle
//             result - product, held until the next completion
//  Revision : 1.0 - initial release
// ============================================================================
module montgomery_mult
    import mod_exp_param_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_steps = c_cnt_w'(WIDTH);

    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [WIDTH-1:0]   m_q,      m_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH:0]     s_q,      s_d;      // partial sum, always < 2m
    logic [c_cnt_w-1:0] cnt_q,    cnt_d;

    // s + a_i*b + q*m < 2m + m + m, so two guard bits are enough.
    logic [WIDTH+1:0]   w_sum_ab;
    logic [WIDTH+1:0]   w_sum;
    logic [WIDTH+1:0]   w_diff;

    always_comb begin
        w_sum_ab = {1'b0, s_q} + (a_q[0] ? {2'b00, b_q} : '0);
        // Adding m when the sum is odd makes it divisible by two.
        w_sum    = w_sum_ab + (w_sum_ab[0] ? {2'b00, m_q} : '0);
        w_diff   = {1'b0, s_q} - {2'b00, m_q};

        busy_d   = busy_q;
        done_d   = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        result_d = result_q;
        s_d      = s_q;
        cnt_d    = cnt_q;

        if (!busy_q) begin
            if (start) begin
                a_d    = a;
                b_d    = b;
                m_d    = m;
                s_d    = '0;
                cnt_d  = c_steps;
                busy_d = 1'b1;
            end
        end else if (cnt_q != '0) begin
            s_d   = (WIDTH + 1)'(w_sum >> 1);
            a_d   = a_q >> 1;
            cnt_d = cnt_q - c_cnt_w'(1);
        end else begin
            result_d = (s_q >= {1'b0, m_q}) ? WIDTH'(w_diff) : s_q[WIDTH-1:0];
            done_d   = 1'b1;
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            result_q <= result_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
`default_nettype wire

// File: rtl/mod_exp_param.sv
`default_nettype none
// ============================================================================
//  Module   : mod_exp_param
//  Purpose  : Left-to-right binary modular exponentiation x^e mod m using a
//             single shared Montgomery multiplier. CONST_TIME=1 selects a
//             fixed square-and-always-multiply schedule independent of e.
//  Ports    : clk, resetn (async, active low)
//             start        - request, only sampled while idle
//             x            - base
//             modulus      - odd modulus m
//             Rmodm        - 2^WIDTH mod m
//             Rsquaredmodm - 2^(2*WIDTH) mod m
//             exponent     - exponent e
//             busy         - high from accepted start until done
//             done         - one-cycle completion pulse
//             result       - x^e mod m, held until overwritten
//  Revision : 1.0 - initial release
// ============================================================================
module mod_exp_param
    import mod_exp_param_pkg::*;
#(
    parameter int WIDTH      = c_default_width,
    parameter int EXP_WIDTH  = c_default_exp_width,
    parameter int CONST_TIME = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     modulus,
    input  logic [WIDTH-1:0]     Rmodm,
    input  logic [WIDTH-1:0]     Rsquaredmodm,
    input  logic [EXP_WIDTH-1:0] exponent,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result
);

    localparam int                 c_cnt_w      = $clog2(EXP_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_exp_bits   = c_cnt_w'(EXP_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]   c_one        = WIDTH'(1);
    localparam bit                 c_const_time = (CONST_TIME != 0);

    state_e               state_q,  state_d;
    logic [WIDTH-1:0]     x_q,      x_d;
    logic [WIDTH-1:0]     mod_q,    mod_d;
    logic [WIDTH-1:0]     rmodm_q,  rmodm_d;
    logic [WIDTH-1:0]     r2_q,     r2_d;
    logic [EXP_WIDTH-1:0] exp_q,    exp_d;     // current bit is always the MSB
    logic [c_cnt_w-1:0]   cnt_q,    cnt_d;     // exponent bits still to process
    logic [WIDTH-1:0]     xm_q,     xm_d;      // base in Montgomery domain
    logic [WIDTH-1:0]     acc_q,    acc_d;     // accumulator A
    logic [WIDTH-1:0]     dummy_q,  dummy_d;   // sink for balanced multiplies
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 issued_q, issued_d;  // product already requested

    logic                 mm_start;
    logic                 mm_done;
    logic [WIDTH-1:0]     mm_a;
    logic [WIDTH-1:0]     mm_b;
    logic [WIDTH-1:0]     mm_result;
    logic                 w_mm_state;
    logic                 w_cur_bit;
    logic                 w_advance;

    assign w_cur_bit = exp_q[EXP_WIDTH-1];

    // Operand selection for the shared multiplier.
    always_comb begin
        mm_a       = '0;
        mm_b       = '0;
        w_mm_state = 1'b1;
        case (state_q)
            ST_TO_MONT:   begin mm_a = x_q;   mm_b = r2_q;  end
            ST_SQUARE:    begin mm_a = acc_q; mm_b = acc_q; end
            ST_MULT:      begin mm_a = acc_q; mm_b = xm_q;  end
            ST_FROM_MONT: begin mm_a = acc_q; mm_b = c_one; end
            default:      w_mm_state = 1'b0;
        endcase
    end

    // Next-state logic. Every multiplying state fires mm_start once on entry
    // and then waits for mm_done, so any multiplier latency is tolerated.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        mod_d     = mod_q;
        rmodm_d   = rmodm_q;
        r2_d      = r2_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        xm_d      = xm_q;
        acc_d     = acc_q;
        dummy_d   = dummy_q;
        result_d  = result_q;
        issued_d  = issued_q;
        mm_start  = 1'b0;
        w_advance = 1'b0;

        if (w_mm_state && !issued_q) begin
            mm_start = 1'b1;
            issued_d = 1'b1;
        end
        if (mm_done) begin
            issued_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = x;
                    mod_d   = modulus;
                    rmodm_d = Rmodm;
                    r2_d    = Rsquaredmodm;
                    exp_d   = exponent;
                    state_d = ST_TO_MONT;
                end
            end
            ST_TO_MONT: begin
                if (mm_done) begin
                    xm_d    = mm_result;
                    acc_d   = rmodm_q;        // Montgomery form of 1
                    cnt_d   = c_exp_bits;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (c_const_time) begin
                    state_d = ST_SQUARE;
                end else if (exp_q == '0) begin
                    state_d = ST_FROM_MONT;
                end else if (w_cur_bit) begin
                    state_d = ST_SQUARE;
                end else begin
                    // Strip leading zeros one per cycle.
                    exp_d = exp_q << 1;
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            ST_SQUARE: begin
                if (mm_done) begin
                    acc_d = mm_result;
                    if (c_const_time || w_cur_bit) begin
                        state_d = ST_MULT;
                    end else begin
                        // Zero bit in variable-time mode: no multiply at all.
                        w_advance = 1'b1;
                    end
                end
            end
            ST_MULT: begin
                if (mm_done) begin
                    if (w_cur_bit) begin
                        acc_d = mm_result;
                    end else begin
                        dummy_d = mm_result;
                    end
                    w_advance = 1'b1;
                end
            end
            ST_FROM_MONT: begin
                if (mm_done) begin
                    result_d = mm_result;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_advance) begin
            exp_d   = exp_q << 1;
            cnt_d   = cnt_q - c_cnt_one;
            state_d = (cnt_q == c_cnt_one) ? ST_FROM_MONT : ST_SQUARE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            mod_q    <= '0;
            rmodm_q  <= '0;
            r2_q     <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            xm_q     <= '0;
            acc_q    <= '0;
            dummy_q  <= '0;
            result_q <= '0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            mod_q    <= mod_d;
            rmodm_q  <= rmodm_d;
            r2_q     <= r2_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            xm_q     <= xm_d;
            acc_q    <= acc_d;
            dummy_q  <= dummy_d;
            result_q <= result_d;
            issued_q <= issued_d;
        end
    end

    montgomery_mult #(
        .WIDTH (WIDTH)
    ) u_mm (
        .clk    (clk),
        .resetn (resetn),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .m      (mod_q),
        .done   (mm_done),
        .result (mm_result)
    );

    // Both flags derive directly from the state register, so an
    // asynchronous reset clears them immediately.
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_exp_param
//  Purpose  : Self-checking bench for mod_exp_param (16-bit variable-time,
//             16-bit constant-time and a 512-bit pair of both schedules).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mod_exp_param;
    import mod_exp_param_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [15:0] x16, m16, rm16, r2_16, e16;
    logic [7:0]  eb;
    logic        start_a, start_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [15:0] res_a, res_b;

    logic [511:0] x512, m512, rm512, r2_512;
    logic [7:0]   e512;
    logic         start_c;
    logic         busy_c, done_c, busy_d, done_d;
    logic [511:0] res_c, res_d;

    int n_pass  = 0;
    int n_total = 0;

    mod_exp_param #(.WIDTH(16), .EXP_WIDTH(16), .CONST_TIME(0)) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .x(x16), .modulus(m16),
        .Rmodm(rm16), .Rsquaredmodm(r2_16), .exponent(e16),
        .busy(busy_a), .done(done_a), .result(res_a));

    mod_exp_param #(.WIDTH(16), .EXP_WIDTH(8), .CONST_TIME(1)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .x(x16), .modulus(m16),
        .Rmodm(rm16), .Rsquaredmodm(r2_16), .exponent(eb),
        .busy(busy_b), .done(done_b), .result(res_b));

    mod_exp_param #(.WIDTH(512), .EXP_WIDTH(8), .CONST_TIME(0)) dut_c (
        .clk(clk), .resetn(resetn), .start(start_c), .x(x512), .modulus(m512),
        .Rmodm(rm512), .Rsquaredmodm(r2_512), .exponent(e512),
        .busy(busy_c), .done(done_c), .result(res_c));

    mod_exp_param #(.WIDTH(512), .EXP_WIDTH(8), .CONST_TIME(1)) dut_d (
        .clk(clk), .resetn(resetn), .start(start_c), .x(x512), .modulus(m512),
        .Rmodm(rm512), .Rsquaredmodm(r2_512), .exponent(e512),
        .busy(busy_d), .done(done_d), .result(res_d));

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain square-and-multiply with ordinary modular arithmetic.
    function automatic logic [15:0] ref16(input logic [15:0] x, input logic [15:0] e,
                                          input logic [15:0] m);
        longint unsigned r, b, mm;
        mm = 64'(m);
        r  = 64'd1 % mm;
        b  = 64'(x) % mm;
        for (int i = 15; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * b) % mm;
        end
        return r[15:0];
    endfunction

    function automatic logic [511:0] ref512(input logic [511:0] x, input logic [7:0] e,
                                            input logic [511:0] m);
        logic [1023:0] r, b, mm;
        mm = {512'b0, m};
        r  = 1024'd1 % mm;
        b  = {512'b0, x} % mm;
        for (int i = 7; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * b) % mm;
        end
        return r[511:0];
    endfunction

    // Number of modular multiplications the schedule must issue.
    function automatic int exp_mults(input logic [15:0] e, input int ew, input bit ct);
        int l = 0;
        int p = 0;
        for (int i = 0; i < ew; i++) begin
            if (e[i]) begin
                p++;
                l = i + 1;
            end
        end
        return ct ? (2 + 2 * ew) : (2 + l + p);
    endfunction

    task automatic set_mod16(input logic [15:0] m);
        longint unsigned r;
        m16   = m;
        r     = 64'd65536 % 64'(m);
        rm16  = r[15:0];
        r     = (r * r) % 64'(m);
        r2_16 = r[15:0];
    endtask

    // Runs one exponentiation on dut_a (sel=0) or dut_b (sel=1).
    task automatic run16(input bit sel, input logic [15:0] x, input logic [15:0] e,
                         input bit disturb, output logic [15:0] res, output int nmm,
                         output int ndone, output int cycles, output bit tmo);
        nmm = 0; ndone = 0; cycles = 0; tmo = 1'b1; res = '0;
        x16 = x; e16 = e; eb = e[7:0];
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
            cycles++;
            if (c == 0) check("busy_after_start", sel ? busy_b : busy_a, 1);
            if (disturb && c == 5) begin
                x16 = ~x; e16 = ~e; eb = ~e[7:0];
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            if (sel ? dut_b.mm_start : dut_a.mm_start) nmm++;
            if (sel ? done_b : done_a) begin
                ndone++;
                res = sel ? res_b : res_a;
                tmo = 1'b0;
                check("busy_low_at_done", sel ? busy_b : busy_a, 0);
                break;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (sel ? done_b : done_a) ndone++;
        end
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] e;
        logic [15:0] exp_res;
    } vec_t;

    vec_t        tbl[12];
    logic [15:0] r16;
    int          nmm, ndone, cyc, cyc1;
    bit          tmo, found;

    initial begin
        logic [15:0] rx, re, rm;
        logic [1023:0] t;
        logic [511:0]  ref_c;
        int nc, nd;
        bit gotc, gotd;

        tbl[0]  = '{16'h0005, 16'h0003, 16'h007D};
        tbl[1]  = '{16'h0002, 16'h0010, 16'h00E1};
        tbl[2]  = '{16'h0007, 16'h0000, 16'h0001};
        tbl[3]  = '{16'h0007, 16'h0001, 16'h0007};
        tbl[4]  = '{16'h0000, 16'h0005, 16'h0000};
        tbl[5]  = '{16'h0000, 16'h0000, 16'h0001};
        tbl[6]  = '{16'h00F1, 16'h0001, 16'h0000};
        tbl[7]  = '{16'hFFFF, 16'h0001, 16'h00E0};
        tbl[8]  = '{16'h0003, 16'h0005, 16'h0002};
        tbl[9]  = '{16'h00F0, 16'h0002, 16'h0001};
        tbl[10] = '{16'h00F0, 16'h0003, 16'h00F0};
        tbl[11] = '{16'h0001, 16'h8000, 16'h0001};

        resetn = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        x16 = '0; e16 = '0; eb = '0; x512 = '0; m512 = '0; rm512 = '0; r2_512 = '0; e512 = '0;
        set_mod16(16'h00F1);
        repeat (3) @(negedge clk);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_result", res_a, 0);
        check("reset_rmodm_setup", rm16, 16'h00E1);
        resetn = 1'b1;

        // Table vectors, m = 0xF1.
        for (int i = 0; i < 12; i++) begin
            run16(1'b0, tbl[i].x, tbl[i].e, 1'b0, r16, nmm, ndone, cyc, tmo);
            check("tbl_timeout", tmo, 0);
            check($sformatf("tbl%0d_result", i), r16, tbl[i].exp_res);
            check($sformatf("tbl%0d_mults", i), nmm, exp_mults(tbl[i].e, 16, 1'b0));
            check($sformatf("tbl%0d_done_pulses", i), ndone, 1);
        end

        // Randomized moduli/bases/exponents against the reference model.
        for (int i = 0; i < 20; i++) begin
            rm = 16'($urandom_range(3, 65535)) | 16'h0001;
            rx = 16'($urandom);
            re = (i < 5) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            set_mod16(rm);
            run16(1'b0, rx, re, 1'b0, r16, nmm, ndone, cyc, tmo);
            check("rnd_timeout", tmo, 0);
            check($sformatf("rnd%0d_result", i), r16, ref16(rx, re, rm));
            check($sformatf("rnd%0d_mults", i), nmm, exp_mults(re, 16, 1'b0));
        end

        // Input changes and a second start while busy must not disturb the job.
        set_mod16(16'h00F1);
        run16(1'b0, 16'h0005, 16'h0003, 1'b1, r16, nmm, ndone, cyc, tmo);
        check("disturb_result", r16, 16'h007D);
        check("disturb_done_pulses", ndone, 1);

        // Asynchronous reset in the middle of a squaring.
        set_mod16(16'h00F1);
        x16 = 16'h0009; e16 = 16'hFFFF; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (dut_a.state_q == ST_SQUARE && c > 30) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached_square", found, 1);
        check("result_held_before_reset", res_a, 16'h007D);
        resetn = 1'b0;
        #1;
        check("midrun_reset_busy", busy_a, 0);
        check("midrun_reset_done", done_a, 0);
        check("midrun_reset_result", res_a, 0);
        @(negedge clk);
        resetn = 1'b1;
        run16(1'b0, 16'h0009, 16'h0021, 1'b0, r16, nmm, ndone, cyc, tmo);
        check("post_reset_result", r16, ref16(16'h0009, 16'h0021, 16'h00F1));
        check("post_reset_done_pulses", ndone, 1);

        // Constant-time schedule: same multiply count and cycles for any e.
        run16(1'b1, 16'h0005, 16'h0001, 1'b0, r16, nmm, ndone, cyc1, tmo);
        check("ct_e01_result", r16, 16'h0005);
        check("ct_e01_mults", nmm, 18);
        run16(1'b1, 16'h0005, 16'h00FF, 1'b0, r16, nmm, ndone, cyc, tmo);
        check("ct_eff_result", r16, ref16(16'h0005, 16'h00FF, 16'h00F1));
        check("ct_eff_mults", nmm, 18);
        check("ct_equal_cycles", cyc, cyc1);
        for (int i = 0; i < 4; i++) begin
            rm = 16'($urandom_range(3, 65535)) | 16'h0001;
            rx = 16'($urandom);
            re = {8'h00, 8'($urandom)};
            set_mod16(rm);
            run16(1'b1, rx, re, 1'b0, r16, nmm, ndone, cyc, tmo);
            check($sformatf("ct_rnd%0d_result", i), r16, ref16(rx, re, rm));
            check($sformatf("ct_rnd%0d_cycles", i), cyc, cyc1);
        end

        // 512-bit operands, both schedules side by side.
        for (int i = 0; i < 16; i++) begin
            m512[i*32 +: 32] = $urandom;
            x512[i*32 +: 32] = $urandom;
        end
        m512[511] = 1'b1;
        m512[0]   = 1'b1;
        t      = (1024'd1 << 512) % {512'b0, m512};
        rm512  = t[511:0];
        t      = (t * t) % {512'b0, m512};
        r2_512 = t[511:0];
        e512   = 8'hB7;
        ref_c  = ref512(x512, e512, m512);
        start_c = 1'b1;
        nc = 0; nd = 0; gotc = 1'b0; gotd = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            start_c = 1'b0;
            if (dut_c.mm_start) nc++;
            if (dut_d.mm_start) nd++;
            if (done_c) begin gotc = 1'b1; check("w512_ct0_result", res_c, ref_c); end
            if (done_d) begin gotd = 1'b1; check("w512_ct1_result", res_d, ref_c); end
            if (gotc && gotd) break;
        end
        check("w512_ct0_finished", gotc, 1);
        check("w512_ct1_finished", gotd, 1);
        check("w512_ct0_mults", nc, 16);
        check("w512_ct1_mults", nd, 18);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
